uart_rx_lcd_feeder: RTL
=======================

Name: uart_rx_lcd_feeder

Overview:
- Upstream stage of the LCD character controller: receives 8N1 UART bytes from the serial line and buffers them in a FIFO.
- Delivers bytes one at a time over the LCD controller's valid/ready character handshake (o_Data_Valid / o_Data_Character against i_Display_Ready).
- Decouples the UART line rate from LCD write, shift and clear times, so bytes arriving while the display is busy are not lost.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200).
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 entries.

Ports:
- clock  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 resets the block.
- i_RX_Serial  in  1  UART line, idle high, asynchronous to clock.
- i_Display_Ready  in  1  LCD controller ready to take a character.
- o_Data_Valid  out  1  single-cycle character strobe to the LCD.
- o_Data_Character  out  8  character to the LCD; held stable between strobes.
- o_FIFO_Count  out  FIFO_AW+1  current FIFO occupancy, 0..2**FIFO_AW.
- o_Overflow  out  1  one-cycle pulse when a received byte is dropped because the FIFO is full.
- o_Frame_Error  out  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FIFO empty, both FSMs idle, synchronizer flops set to 1.
- Input sync: i_RX_Serial passes through 2 flops; all RX logic uses the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on synchronized line = 0, go to START with bit counter cleared.
  - START: at count = (CLKS_PER_BIT-1)/2, a low line goes to DATA with counter cleared. A high line is a glitch: return to IDLE, no error.
  - DATA: sample at count = CLKS_PER_BIT-1, then clear the counter. Bits are shifted in LSB first. After bit index 7, go to STOP.
  - STOP: sample at count = CLKS_PER_BIT-1.
    - High: issue a push strobe for 1 cycle and go to IDLE.
    - Low: pulse o_Frame_Error, discard the byte, go to BREAK.
  - BREAK: wait for the synchronized line = 1, then go to IDLE. No new start bit is detected during a break.
- FIFO: 2**FIFO_AW x 8, binary read/write pointers that wrap naturally; count is registered.
  - A push is accepted iff count < 2**FIFO_AW. This holds even if a pop occurs the same cycle (no full-bypass).
  - A rejected push pulses o_Overflow for 1 cycle. FIFO contents are unchanged.
  - Simultaneous accepted push and pop leave count unchanged.
  - o_FIFO_Count updates the cycle after each push or pop.
- Output FSM states: OUT_IDLE, OUT_HOLD.
  - OUT_IDLE: if count > 0 and i_Display_Ready = 1:
    - load o_Data_Character from the FIFO head;
    - set o_Data_Valid = 1 for the next cycle only;
    - pop;
    - go to OUT_HOLD.
  - OUT_HOLD: o_Data_Valid = 0. Stay until i_Display_Ready is sampled 0, then return to OUT_IDLE. This blocks a second strobe before the LCD has dropped ready.
  - o_Data_Character holds its value until the next pop. The LCD may re-read it during its shift sequence.
  - No timeout: if ready never drops, the FSM stays in OUT_HOLD.
- Latency: with the FIFO empty and ready = 1, the push at the stop-bit sample cycle N gives o_Data_Valid = 1 at cycle N+2.
- Bytes are forwarded untouched, including 0x0A and 0x0D. Interpreting them is the LCD controller's job.

Test Plan:
- Reset, line idle high -> all outputs 0, o_FIFO_Count = 0, no pulses for 10000 cycles.
- Send 0x41, LCD model ready = 1, drops ready 1 cycle after the strobe and restores it after 3584 cycles -> one o_Data_Valid pulse, o_Data_Character = 0x41 held until the next pop, count returns to 0.
- Ready held 0, send 0x31..0x3F then 0x40, 0x5A (17 bytes) -> count reaches 16, one o_Overflow pulse on 0x5A. After ready rises, characters appear in order 0x31..0x40 with exactly one strobe per ready cycle.
- Stop bit driven low on byte 0x55, line held low 2 bit times then high -> one o_Frame_Error pulse, no push. The next good byte 0x33 is received correctly.
- Low glitch of CLKS_PER_BIT/4 cycles on the idle line -> no push, no error, RX returns to IDLE.
- Async reset asserted mid-DATA with 3 bytes queued -> outputs 0 immediately, FIFO empty. After release, the next full frame 0x7A is received normally.

Source files
------------

// File: rtl/uart_rx_lcd_feeder.sv
// 8N1 UART receiver -> byte FIFO -> one-character-per-ready-cycle strobe to the LCD controller.
// A byte arriving at a full FIFO is dropped and flagged; a low stop bit is flagged and the byte discarded.
module uart_rx_lcd_feeder #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_AW      = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               i_RX_Serial,
   input  logic               i_Display_Ready,
   output logic               o_Data_Valid,
   output logic [7:0]         o_Data_Character,
   output logic [FIFO_AW:0]   o_FIFO_Count,
   output logic               o_Overflow,
   output logic               o_Frame_Error
);
   localparam int DEPTH = 2**FIFO_AW;
   localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] MID_CNT = CW'((CLKS_PER_BIT-1)/2);
   localparam logic [CW-1:0] END_CNT = CW'(CLKS_PER_BIT-1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;
   typedef enum logic {OUT_IDLE, OUT_HOLD} out_state_e;

   logic               rx_meta_q, rx_sync_q;
   rx_state_e          rx_state_q, rx_state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2:0]         bit_idx_q, bit_idx_d;
   logic [7:0]         shift_q, shift_d;
   logic               push, frame_err;
   logic               frame_err_q, overflow_q;

   logic [7:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               push_ok, pop;

   out_state_e         out_state_q, out_state_d;
   logic               valid_q, valid_d;
   logic [7:0]         char_q, char_d;

   // Line idles high, so the synchronizer resets to 1 to avoid a false start bit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= i_RX_Serial;
         rx_sync_q <= rx_meta_q;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      push       = 1'b0;
      frame_err  = 1'b0;
      case (rx_state_q)
         IDLE: if (!rx_sync_q) begin
            rx_state_d = START;
            cnt_d      = '0;
         end
         START: if (cnt_q == MID_CNT) begin
            cnt_d      = '0;
            bit_idx_d  = '0;
            rx_state_d = rx_sync_q ? IDLE : DATA;
         end else cnt_d = cnt_q + 1'b1;
         DATA: if (cnt_q == END_CNT) begin
            cnt_d   = '0;
            shift_d = {rx_sync_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) rx_state_d = STOP;
            else                   bit_idx_d  = bit_idx_q + 1'b1;
         end else cnt_d = cnt_q + 1'b1;
         STOP: if (cnt_q == END_CNT) begin
            cnt_d = '0;
            if (rx_sync_q) begin
               push       = 1'b1;
               rx_state_d = IDLE;
            end else begin
               frame_err  = 1'b1;
               rx_state_d = BREAK;
            end
         end else cnt_d = cnt_q + 1'b1;
         BREAK: if (rx_sync_q) rx_state_d = IDLE;
         default: rx_state_d = IDLE;
      endcase
   end

   // Full is judged on the registered count alone, even when a pop lands in the same cycle.
   assign push_ok = push & ~count_q[FIFO_AW];
   assign pop     = (out_state_q == OUT_IDLE) && (count_q != '0) && i_Display_Ready;

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      out_state_d = out_state_q;
      valid_d     = 1'b0;
      char_d      = char_q;
      case (out_state_q)
         OUT_IDLE: if (pop) begin
            valid_d     = 1'b1;
            char_d      = mem_q[rd_ptr_q];
            out_state_d = OUT_HOLD;
         end
         OUT_HOLD: if (!i_Display_Ready) out_state_d = OUT_IDLE;
         default:  out_state_d = OUT_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem_q[wr_ptr_q] <= shift_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_state_q  <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_state_q <= OUT_IDLE;
         valid_q     <= 1'b0;
         char_q      <= '0;
      end else begin
         rx_state_q  <= rx_state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err;
         overflow_q  <= push & count_q[FIFO_AW];
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q     <= count_d;
         out_state_q <= out_state_d;
         valid_q     <= valid_d;
         char_q      <= char_d;
      end
   end

   assign o_Data_Valid     = valid_q;
   assign o_Data_Character = char_q;
   assign o_FIFO_Count     = count_q;
   assign o_Overflow       = overflow_q;
   assign o_Frame_Error    = frame_err_q;
endmodule
